// File: rtl/acorn_seq_if.sv
// Host/datapath-facing bundle of the ACORN-128 phase sequencer.
// The master drives start/abort/dp_ready; the sequencer (slave) returns the step controls.
interface acorn_seq_if;
  logic        start;
  logic        abort;
  logic        dp_ready;
  logic        busy;
  logic        done;
  logic [2:0]  phase;
  logic [10:0] step_idx;
  logic        step_en;
  logic        ca;
  logic        cb;
  logic [2:0]  msel;
  logic        mflip;
  logic        ks_take;
  logic [6:0]  out_idx;

  modport master (
    output start, abort, dp_ready,
    input  busy, done, phase, step_idx, step_en, ca, cb, msel, mflip, ks_take, out_idx
  );
  modport slave (
    input  start, abort, dp_ready,
    output busy, done, phase, step_idx, step_en, ca, cb, msel, mflip, ks_take, out_idx
  );
endinterface

// File: rtl/acorn_phase_sequencer.sv
// Sequences one ACORN-128 run (INIT -> AD -> ENC -> FIN -> DONE). Only phase and
// step index are registered; every per-step control is decoded from them.
module acorn_phase_sequencer #(
  parameter int INIT_STEPS = 1792,
  parameter int PAD_STEPS  = 384,
  parameter int FIN_STEPS  = 768,
  parameter int TAG_BITS   = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  acorn_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0, PH_INIT = 3'd1, PH_AD = 3'd2,
    PH_ENC  = 3'd3, PH_FIN  = 3'd4, PH_DONE = 3'd5
  } phase_e;

  localparam logic [10:0] INIT_LAST = 11'(INIT_STEPS - 1);
  localparam logic [10:0] PAD_LAST  = 11'(PAD_STEPS - 1);
  localparam logic [10:0] FIN_LAST  = 11'(FIN_STEPS - 1);
  localparam logic [10:0] TAG_START = 11'(FIN_STEPS - TAG_BITS);

  phase_e      phase_q, phase_d;
  logic [10:0] step_q, step_d, last_step;
  logic        busy, step_en;
  logic        ca, cb, mflip, ks_take;
  logic [2:0]  msel;
  logic [6:0]  out_idx;
  logic        lt128, eq128, lt256, eq256;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      step_q  <= '0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  assign busy    = (phase_q == PH_INIT) || (phase_q == PH_AD) ||
                   (phase_q == PH_ENC)  || (phase_q == PH_FIN);
  assign step_en = busy & bus.dp_ready;

  always_comb begin
    case (phase_q)
      PH_INIT: last_step = INIT_LAST;
      PH_FIN:  last_step = FIN_LAST;
      default: last_step = PAD_LAST;
    endcase
  end

  // abort outranks everything, including a start seen in IDLE
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    if (bus.abort) begin
      phase_d = PH_IDLE;
      step_d  = '0;
    end else begin
      case (phase_q)
        PH_IDLE: if (bus.start) begin
          phase_d = PH_INIT;
          step_d  = '0;
        end
        PH_INIT, PH_AD, PH_ENC, PH_FIN: if (step_en) begin
          if (step_q == last_step) begin
            phase_d = phase_e'(phase_q + 3'd1);
            step_d  = '0;
          end else begin
            step_d = step_q + 11'd1;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  assign lt128 = step_q < 11'd128;
  assign eq128 = step_q == 11'd128;
  assign lt256 = step_q < 11'd256;
  assign eq256 = step_q == 11'd256;

  always_comb begin
    ca      = 1'b0;
    cb      = 1'b0;
    msel    = 3'd0;
    mflip   = 1'b0;
    ks_take = 1'b0;
    out_idx = 7'd0;
    case (phase_q)
      PH_INIT: begin
        ca    = 1'b1;
        cb    = 1'b1;
        msel  = (!lt128 && lt256) ? 3'd2 : 3'd1;
        mflip = eq256;
      end
      PH_AD: begin
        ca   = lt256;
        cb   = 1'b1;
        msel = lt128 ? 3'd3 : (eq128 ? 3'd5 : 3'd0);
      end
      PH_ENC: begin
        ca      = lt256;
        msel    = lt128 ? 3'd4 : (eq128 ? 3'd5 : 3'd0);
        ks_take = lt128;
        out_idx = step_q[6:0];
      end
      PH_FIN: begin
        ca      = 1'b1;
        cb      = 1'b1;
        ks_take = step_q >= TAG_START;
        // tag bit position wraps mod 128, so only the low bits matter
        out_idx = step_q[6:0] - TAG_START[6:0];
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = (phase_q == PH_DONE);
  assign bus.phase    = phase_q;
  assign bus.step_idx = step_q;
  assign bus.step_en  = step_en;
  assign bus.ca       = ca;
  assign bus.cb       = cb;
  assign bus.msel     = msel;
  assign bus.mflip    = mflip;
  assign bus.ks_take  = ks_take;
  assign bus.out_idx  = out_idx;
endmodule

// File: doc/acorn_phase_sequencer.md
# acorn_phase_sequencer

Control FSM that sequences one full ACORN-128 authenticated-encryption run over the state-update/keystream datapath: initialization, associated-data absorption, plaintext encryption and finalization/tag generation. Each cycle it drives the per-step controls (`ca`, `cb`, message-bit source select, key-flip), the step index, and the keystream-capture strobe/index. It sits between the top-level host handshake and the `state_update128`/`ksg128` datapath and replaces ad-hoc `icount` decoding inside individual phase blocks.

## Interface
Parameters:
- `INIT_STEPS`, 1792: initialization steps; must be ≤ 2048.
- `PAD_STEPS`, 384: steps in the AD phase and in the ENC phase.
- `FIN_STEPS`, 768: finalization steps.
- `TAG_BITS`, 128: tag bits, taken from the last `TAG_BITS` finalization steps.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: synchronous return to IDLE; beats `start`.
- `dp_ready` in 1: datapath can take a step this cycle. Low stalls the sequencer.
- `busy` out 1: high in INIT, AD, ENC and FIN.
- `done` out 1: one-cycle pulse in the DONE state.
- `phase` out 3: 0 IDLE, 1 INIT, 2 AD, 3 ENC, 4 FIN, 5 DONE.
- `step_idx` out 11: step index within the current phase.
- `step_en` out 1: datapath advances this cycle; `step_en = busy & dp_ready`.
- `ca` out 1, `cb` out 1: control bits for the current step.
- `msel` out 3: message-bit source. 0 zero, 1 key[i mod 128], 2 iv[i-128], 3 ad[i], 4 pt[i], 5 constant one.
- `mflip` out 1: invert the selected key bit.
- `ks_take` out 1: the keystream bit this step is output data (ciphertext or tag).
- `out_idx` out 7: bit position for `ks_take`.

## Operation
- State is held in two registers: `phase` and `step_idx`. Every other output is combinational from those two plus `dp_ready`.
- IDLE:
  - `start=1` → INIT with `step_idx=0`.
  - `start` in any other state is ignored.
- Active phases:
  - Each `step_en` cycle, `step_idx` increments.
  - On the last step of a phase (`step_idx == N-1` with `step_en`), `phase` advances and `step_idx` returns to 0.
  - Order: INIT(`INIT_STEPS`) → AD(`PAD_STEPS`) → ENC(`PAD_STEPS`) → FIN(`FIN_STEPS`) → DONE.
- DONE: lasts one cycle with `done=1`, then goes to IDLE unconditionally.
- Control decoding, with i = `step_idx`:
  - INIT: `ca=1`, `cb=1`. `msel` = 1 for i<128, 2 for 128≤i<256, 1 for i≥256. `mflip=1` only at i=256.
  - AD: `ca=(i<256)`, `cb=1`. `msel` = 3 for i<128, 5 at i=128, 0 otherwise.
  - ENC: `ca=(i<256)`, `cb=0`. `msel` = 4 for i<128, 5 at i=128, 0 otherwise. `ks_take=(i<128)`, `out_idx=i[6:0]`.
  - FIN: `ca=1`, `cb=1`, `msel=0`. `ks_take=(i ≥ FIN_STEPS-TAG_BITS)`, `out_idx=(i-(FIN_STEPS-TAG_BITS))[6:0]`.
  - IDLE/DONE: all step controls 0.
- `abort=1` in any state → IDLE with `step_idx=0` on the next edge. No `done` pulse. `abort` and `start` together in IDLE → remain in IDLE.
- `dp_ready=0`: `phase` and `step_idx` hold, `step_en=0`, and the decoded controls remain valid and stable.

## Timing
- Reset values: `phase`=IDLE, `step_idx`=0. All outputs are 0.
- Reset is asserted asynchronously at any time, including mid-run. The first edge after deassertion sees IDLE and requires a fresh `start`.
- `start` sampled at edge E0 → `phase=1`, `busy=1` from E0.
- With `dp_ready` held high, there are 3328 stepping cycles. The last FIN step edge is E3328. `done=1` during the cycle following E3328. `phase=0` after E3329.
- Controls for step i are valid in the same cycle as `step_en`, before the edge that commits step i.
- Stalls add latency one-for-one and never skip or repeat a step.

## Test plan
- Full run, `dp_ready=1`, `start` pulse at E0 → exactly 3328 `step_en` cycles; 128 `ks_take` in ENC with `out_idx` 0..127; 128 `ks_take` in FIN at i=640..767 with `out_idx` 0..127; single `done` after E3328.
- Boundary decode:
  - INIT i=127/128/255/256/257 → `msel` 1/2/2/1/1, `mflip` only at 256.
  - AD i=128 → `msel=5`.
  - ENC i=255 → `ca=1`; i=256 → `ca=0`, `cb=0`.
  - FIN i=639 → `ks_take=0`; i=640 → `ks_take=1`.
- Stall: random `dp_ready` (~50% duty) → identical control/step trace to the full run after removing stall cycles; `done` delayed by exactly the number of stall cycles.
- Abort: `abort` at ENC i=200 → IDLE next edge, no `done`. A new `start` → INIT from i=0.
- Spurious start: `start` pulses during AD → ignored (trace unchanged). `start`+`abort` together in IDLE → stays IDLE.
- Reset mid-run: `rst_n` low asynchronously in FIN i=700 → outputs 0 immediately. After release, IDLE until `start`.
